// File: rtl/char_cycler.sv
// char_cycler: cursor-selected multi-digit code stepper with wrap, lock code and auto-repeat
module char_cycler #(
  parameter int N_DIGITS   = 4,
  parameter int W          = 4,
  parameter int MIN_CODE   = 1,
  parameter int MAX_CODE   = 10,
  parameter int LOCK_CODE  = 4,
  parameter int RESET_CODE = 1,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000,
  localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_btn_up,
  input  logic                  i_btn_down,
  input  logic                  i_btn_left,
  input  logic                  i_btn_right,
  input  logic                  i_load_en,
  input  logic [W-1:0]          i_load_val,
  output logic [N_DIGITS*W-1:0] o_codes,
  output logic [CW-1:0]         o_cursor,
  output logic                  o_step_pulse
);
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int CNW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [W-1:0] L_MIN = W'(MIN_CODE);
  localparam logic [W-1:0] L_MAX = W'(MAX_CODE);
  localparam logic [W-1:0] L_LOCK = W'(LOCK_CODE);
  localparam bit LOCK_ON = (LOCK_CODE >= 0) && (LOCK_CODE < 2**W);
  localparam logic [CW-1:0] L_LAST = CW'(N_DIGITS - 1);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT, S_BLOCK} state_t;
  state_t r_state, w_nstate;
  logic [W-1:0] r_codes [N_DIGITS];
  logic [CW-1:0] r_cursor;
  logic [CNW-1:0] r_cnt, w_ncnt;
  logic [3:0] r_prev;
  logic r_dir, w_ndir, r_step, w_step;
  logic w_up_p, w_dn_p, w_lf_p, w_rt_p, w_held, w_other, w_locked, w_wr;
  logic [W-1:0] w_cur, w_up_val, w_dn_val, w_new;
  assign w_up_p = i_btn_up & ~r_prev[0];
  assign w_dn_p = i_btn_down & ~r_prev[1];
  assign w_lf_p = i_btn_left & ~r_prev[2];
  assign w_rt_p = i_btn_right & ~r_prev[3];
  assign w_cur = r_codes[r_cursor];
  assign w_up_val = (w_cur >= L_MAX || w_cur < L_MIN) ? L_MIN : w_cur + 1'b1;
  assign w_dn_val = (w_cur <= L_MIN || w_cur > L_MAX) ? L_MAX : w_cur - 1'b1;
  assign w_locked = LOCK_ON && (w_cur == L_LOCK);
  assign w_held = r_dir ? i_btn_up : i_btn_down;
  assign w_other = r_dir ? i_btn_down : i_btn_up;
  assign w_wr = i_load_en || (w_step && !w_locked);
  assign w_new = i_load_en ? i_load_val : (w_ndir ? w_up_val : w_dn_val);
  always_comb begin
    w_nstate = r_state;
    w_ncnt = r_cnt;
    w_ndir = r_dir;
    w_step = 1'b0;
    case (r_state)
      S_IDLE:
        if ((w_up_p && i_btn_down) || (w_dn_p && i_btn_up)) w_nstate = S_BLOCK;
        else if (w_up_p || w_dn_p) begin
          w_step = 1'b1;
          w_ndir = w_up_p;
          w_nstate = S_HOLD;
          w_ncnt = '0;
        end
      S_HOLD, S_RPT:
        if (!w_held) w_nstate = S_IDLE;
        else if (w_other) w_nstate = S_BLOCK;
        else if (r_cnt == ((r_state == S_HOLD) ? CNW'(RPT_DELAY - 1) : CNW'(RPT_PERIOD - 1))) begin
          w_step = 1'b1;
          w_nstate = S_RPT;
          w_ncnt = '0;
        end else w_ncnt = r_cnt + 1'b1;
      default: w_nstate = (!i_btn_up && !i_btn_down) ? S_IDLE : S_BLOCK;
    endcase
  end
  // Writes target the cursor as it stood before this cycle's move
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_DIGITS; i++) r_codes[i] <= W'(RESET_CODE);
      r_cursor <= '0;
      r_step <= 1'b0;
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_prev <= '0;
    end else begin
      if (w_wr) r_codes[r_cursor] <= w_new;
      r_step <= w_wr && (w_new != w_cur);
      if (w_rt_p && !w_lf_p) r_cursor <= (r_cursor == L_LAST) ? '0 : r_cursor + 1'b1;
      else if (w_lf_p && !w_rt_p) r_cursor <= (r_cursor == '0) ? L_LAST : r_cursor - 1'b1;
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      r_dir <= w_ndir;
      r_prev <= {i_btn_right, i_btn_left, i_btn_down, i_btn_up};
    end
  end
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_out
    assign o_codes[g*W +: W] = r_codes[g];
  end
  assign o_cursor = r_cursor;
  assign o_step_pulse = r_step;
endmodule

// File: tb/tb_char_cycler.sv
// tb_char_cycler: directed checks of stepping, wrap, lock, cursor, auto-repeat and reset
module tb_char_cycler;
  logic clk = 1'b0, rst = 1'b1;
  logic up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, ld = 1'b0;
  logic [3:0] lv = '0;
  logic [15:0] codes, codes2;
  logic [1:0] cur, cur2;
  logic sp, sp2;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  char_cycler #(.RPT_DELAY(4), .RPT_PERIOD(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_up(up), .i_btn_down(dn), .i_btn_left(lf),
    .i_btn_right(rt), .i_load_en(ld), .i_load_val(lv), .o_codes(codes),
    .o_cursor(cur), .o_step_pulse(sp));
  char_cycler #(.LOCK_CODE(0), .RPT_DELAY(4), .RPT_PERIOD(2)) dut_nl (
    .i_clk(clk), .i_rst(rst), .i_btn_up(up), .i_btn_down(dn), .i_btn_left(lf),
    .i_btn_right(rt), .i_load_en(ld), .i_load_val(lv), .o_codes(codes2),
    .o_cursor(cur2), .o_step_pulse(sp2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick(); tick();
    n_tests++; if (codes !== 16'h1111) begin n_fail++; $display("FAIL reset_codes got=%h exp=1111", codes); end
    n_tests++; if (cur !== 2'd0 || sp !== 1'b0) begin n_fail++; $display("FAIL reset_cur_sp got=%0d/%b exp=0/0", cur, sp); end
    rst = 1'b0;
    tick();
    ld = 1'b1; lv = 4'd7; rt = 1'b1;
    tick();
    ld = 1'b0; rt = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd7 || cur !== 2'd1 || sp !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%h/%0d/%b exp=7/1/1", codes[3:0], cur, sp); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (codes !== 16'h1111) begin n_fail++; $display("FAIL async_reset_codes got=%h exp=1111", codes); end
    n_tests++; if (cur !== 2'd0 || sp !== 1'b0) begin n_fail++; $display("FAIL async_reset_cur_sp got=%0d/%b exp=0/0", cur, sp); end
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_wrap;
    ld = 1'b1; lv = 4'd9;
    tick();
    ld = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd9 || sp !== 1'b1) begin n_fail++; $display("FAIL load9 got=%0d/%b exp=9/1", codes[3:0], sp); end
    up = 1'b1; tick(); up = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd10 || sp !== 1'b1) begin n_fail++; $display("FAIL up_to_10 got=%0d/%b exp=10/1", codes[3:0], sp); end
    tick();
    n_tests++; if (sp !== 1'b0) begin n_fail++; $display("FAIL pulse_width got=%b exp=0", sp); end
    up = 1'b1; tick(); up = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd1 || sp !== 1'b1) begin n_fail++; $display("FAIL up_wrap got=%0d/%b exp=1/1", codes[3:0], sp); end
    tick();
    dn = 1'b1; tick(); dn = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd10 || sp !== 1'b1) begin n_fail++; $display("FAIL down_wrap got=%0d/%b exp=10/1", codes[3:0], sp); end
    tick();
    n_tests++; if (codes[3:0] !== 4'd10 || sp !== 1'b0) begin n_fail++; $display("FAIL down_hold got=%0d/%b exp=10/0", codes[3:0], sp); end
  endtask
  task automatic test_lock;
    ld = 1'b1; lv = 4'd4;
    tick();
    ld = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd4 || sp !== 1'b1) begin n_fail++; $display("FAIL load_lock got=%0d/%b exp=4/1", codes[3:0], sp); end
    up = 1'b1; tick(); up = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd4 || sp !== 1'b0) begin n_fail++; $display("FAIL lock_up got=%0d/%b exp=4/0", codes[3:0], sp); end
    tick();
    dn = 1'b1; tick(); dn = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd4 || sp !== 1'b0) begin n_fail++; $display("FAIL lock_down got=%0d/%b exp=4/0", codes[3:0], sp); end
    tick();
    ld = 1'b1; lv = 4'd5;
    tick();
    n_tests++; if (codes[3:0] !== 4'd5 || sp !== 1'b1) begin n_fail++; $display("FAIL unlock_load got=%0d/%b exp=5/1", codes[3:0], sp); end
    tick();
    ld = 1'b0;
    n_tests++; if (codes[3:0] !== 4'd5 || sp !== 1'b0) begin n_fail++; $display("FAIL same_load got=%0d/%b exp=5/0", codes[3:0], sp); end
  endtask
  task automatic test_cursor;
    logic [1:0] exp_c [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      rt = 1'b1; up = (i == 1); tick(); rt = 1'b0; up = 1'b0;
      n_tests++; if (cur !== exp_c[i]) begin n_fail++; $display("FAIL right_%0d got=%0d exp=%0d", i, cur, exp_c[i]); end
      tick();
    end
    lf = 1'b1; tick(); lf = 1'b0;
    n_tests++; if (cur !== 2'd3) begin n_fail++; $display("FAIL left_wrap got=%0d exp=3", cur); end
    tick();
    lf = 1'b1; rt = 1'b1; tick(); lf = 1'b0; rt = 1'b0;
    n_tests++; if (cur !== 2'd3) begin n_fail++; $display("FAIL left_right got=%0d exp=3", cur); end
    tick();
    rt = 1'b1; tick(); rt = 1'b0;
    tick();
    n_tests++; if (cur !== 2'd0 || codes !== 16'h1125) begin n_fail++; $display("FAIL cursor_codes got=%0d/%h exp=0/1125", cur, codes); end
  endtask
  task automatic test_repeat;
    int e_nl [10] = '{2, 2, 2, 2, 3, 3, 4, 4, 5, 5};
    int e_lk [10] = '{2, 2, 2, 2, 3, 3, 4, 4, 4, 4};
    rst = 1'b1; tick(); rst = 1'b0; tick();
    up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++; if (codes2[3:0] !== 4'(e_nl[i]) || sp2 !== (i == 0 || i == 4 || i == 6 || i == 8)) begin
        n_fail++; $display("FAIL rpt_nolock_%0d got=%0d/%b exp=%0d", i, codes2[3:0], sp2, e_nl[i]);
      end
      n_tests++; if (codes[3:0] !== 4'(e_lk[i])) begin n_fail++; $display("FAIL rpt_lock_%0d got=%0d exp=%0d", i, codes[3:0], e_lk[i]); end
    end
    up = 1'b0;
    tick(); tick();
    n_tests++; if (codes2[3:0] !== 4'd5 || codes[3:0] !== 4'd4) begin n_fail++; $display("FAIL rpt_final got=%0d/%0d exp=5/4", codes2[3:0], codes[3:0]); end
  endtask
  task automatic test_block;
    up = 1'b1; tick(); tick();
    n_tests++; if (codes2[3:0] !== 4'd6) begin n_fail++; $display("FAIL block_first got=%0d exp=6", codes2[3:0]); end
    dn = 1'b1;
    repeat (4) tick();
    n_tests++; if (codes2[3:0] !== 4'd6) begin n_fail++; $display("FAIL block_both got=%0d exp=6", codes2[3:0]); end
    up = 1'b0;
    repeat (3) tick();
    n_tests++; if (codes2[3:0] !== 4'd6 || sp2 !== 1'b0) begin n_fail++; $display("FAIL block_down_only got=%0d/%b exp=6/0", codes2[3:0], sp2); end
    dn = 1'b0; tick();
    up = 1'b1; tick(); up = 1'b0;
    n_tests++; if (codes2[3:0] !== 4'd7 || sp2 !== 1'b1) begin n_fail++; $display("FAIL block_repress got=%0d/%b exp=7/1", codes2[3:0], sp2); end
    tick(); tick();
    n_tests++; if (codes2[3:0] !== 4'd7 || sp2 !== 1'b0) begin n_fail++; $display("FAIL block_single got=%0d/%b exp=7/0", codes2[3:0], sp2); end
  endtask
  task automatic test_reset_rpt;
    up = 1'b1;
    repeat (5) tick();
    n_tests++; if (codes2[3:0] !== 4'd9) begin n_fail++; $display("FAIL rpt_before_reset got=%0d exp=9", codes2[3:0]); end
    tick();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (codes2 !== 16'h1111 || sp2 !== 1'b0) begin n_fail++; $display("FAIL rpt_reset got=%h/%b exp=1111/0", codes2, sp2); end
    up = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_tests++; if (codes2 !== 16'h1111) begin n_fail++; $display("FAIL rpt_after_reset got=%h exp=1111", codes2); end
    up = 1'b1; tick(); up = 1'b0;
    n_tests++; if (codes2[3:0] !== 4'd2 || sp2 !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset got=%0d/%b exp=2/1", codes2[3:0], sp2); end
    tick(); tick();
    n_tests++; if (codes2[3:0] !== 4'd2) begin n_fail++; $display("FAIL idle_single got=%0d exp=2", codes2[3:0]); end
  endtask
  initial begin
    test_reset();
    test_wrap();
    test_lock();
    test_cursor();
    test_repeat();
    test_block();
    test_reset_rpt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
